// File: rtl/data_memory_pkg.sv
// Processor-wide data-memory sizing and memory-mapped I/O addresses.
// Also holds the address decoder shared by the data memory read and write paths.
package data_memory_pkg;

  localparam int DBITS        = 32;
  localparam int DMEMADDRBITS = 13;
  localparam int DMEMWORDBITS = 2;
  localparam int DMEMWORDS    = 2048;

  localparam logic [DBITS-1:0] ADDR_HEX  = 32'hF0000000;
  localparam logic [DBITS-1:0] ADDR_LEDR = 32'hF0000004;
  localparam logic [DBITS-1:0] ADDR_LEDG = 32'hF0000008;
  localparam logic [DBITS-1:0] ADDR_KEY  = 32'hF0000010;
  localparam logic [DBITS-1:0] ADDR_SW   = 32'hF0000014;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_HEX,
    SEL_LEDR,
    SEL_LEDG,
    SEL_KEY,
    SEL_SW,
    SEL_NONE
  } dsel_t;

  // Anything outside the 0xF nibble is RAM; inside it only exact matches decode.
  function automatic dsel_t decode_addr(input logic [DBITS-1:0] a);
    dsel_t sel;
    if (a[DBITS-1:DBITS-4] != 4'hF) begin
      sel = SEL_RAM;
    end else begin
      case (a)
        ADDR_HEX:  sel = SEL_HEX;
        ADDR_LEDR: sel = SEL_LEDR;
        ADDR_LEDG: sel = SEL_LEDG;
        ADDR_KEY:  sel = SEL_KEY;
        ADDR_SW:   sel = SEL_SW;
        default:   sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/data_memory_seven_seg.sv
// Hex nibble to active-low 7-segment pattern (bit order gfedcba).
// Purely combinational, zero latency, no flow control.
module seven_seg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Data-side RAM (2048x32) plus memory-mapped HEX/LEDR/LEDG registers and KEY/SW inputs.
// Writes land on the clock edge; reads are combinational (zero latency); no backpressure.
module data_memory
  import data_memory_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wrMEM,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] dataIn,
  input  logic [9:0]       switches,
  input  logic [3:0]       keys,
  output logic [9:0]       ledr,
  output logic [7:0]       ledg,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [DBITS-1:0] dataOut
);

  localparam int WIDX = DMEMADDRBITS - DMEMWORDBITS;

  logic [DBITS-1:0] mem [DMEMWORDS];
  logic [15:0]      hexreg;
  logic [WIDX-1:0]  widx;
  dsel_t            sel;

  assign sel  = decode_addr(addr);
  assign widx = addr[DMEMADDRBITS-1:DMEMWORDBITS];

  // RAM has no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (wrMEM && sel == SEL_RAM) begin
      mem[widx] <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hexreg <= '0;
      ledr   <= '0;
      ledg   <= '0;
    end else if (wrMEM) begin
      case (sel)
        SEL_HEX:  hexreg <= dataIn[15:0];
        SEL_LEDR: ledr   <= dataIn[9:0];
        SEL_LEDG: ledg   <= dataIn[7:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    dataOut = '0;
    case (sel)
      SEL_RAM:  dataOut = mem[widx];
      SEL_HEX:  dataOut = {{(DBITS-16){1'b0}}, hexreg};
      SEL_LEDR: dataOut = {{(DBITS-10){1'b0}}, ledr};
      SEL_LEDG: dataOut = {{(DBITS-8){1'b0}}, ledg};
      SEL_KEY:  dataOut = {{(DBITS-4){1'b0}}, keys};
      SEL_SW:   dataOut = {{(DBITS-10){1'b0}}, switches};
      default:  dataOut = '0;
    endcase
  end

  seven_seg_decoder u_seg0 (.nibble(hexreg[3:0]),   .seg(hex0));
  seven_seg_decoder u_seg1 (.nibble(hexreg[7:4]),   .seg(hex1));
  seven_seg_decoder u_seg2 (.nibble(hexreg[11:8]),  .seg(hex2));
  seven_seg_decoder u_seg3 (.nibble(hexreg[15:12]), .seg(hex3));

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, mid-run reset, then random ops vs a reference model.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wrMEM;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic [9:0]  switches;
  logic [3:0]  keys;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [31:0] dataOut;

  data_memory dut (
    .clk(clk), .reset_n(reset_n), .wrMEM(wrMEM), .addr(addr), .dataIn(dataIn),
    .switches(switches), .keys(keys), .ledr(ledr), .ledg(ledg),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  logic [6:0] seg_tbl [16];

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [9:0]  sw;
    logic [3:0]  k;
    logic        cd;
    logic [31:0] edout;
    logic [9:0]  eledr;
    logic [7:0]  eledg;
    logic [27:0] ehex;
  } vec_t;

  vec_t tv [$];

  // reference model state
  logic [31:0] mref   [2048];
  bit          mvalid [2048];
  logic [15:0] hexm;
  logic [9:0]  ledrm;
  logic [7:0]  ledgm;

  function automatic vec_t mkv(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [9:0] sw, input logic [3:0] k, input logic cd,
                               input logic [31:0] edout, input logic [9:0] eledr,
                               input logic [7:0] eledg, input logic [27:0] ehex);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.sw = sw; v.k = k; v.cd = cd;
    v.edout = edout; v.eledr = eledr; v.eledg = eledg; v.ehex = ehex;
    return v;
  endfunction

  function automatic logic [27:0] hex_of(input logic [15:0] v);
    return {seg_tbl[v[15:12]], seg_tbl[v[11:8]], seg_tbl[v[7:4]], seg_tbl[v[3:0]]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_io(input string name, input logic [9:0] el, input logic [7:0] eg,
                        input logic [27:0] eh);
    chk({name, " ledr"}, {22'b0, ledr}, {22'b0, el});
    chk({name, " ledg"}, {24'b0, ledg}, {24'b0, eg});
    chk({name, " hex"}, {4'b0, hex3, hex2, hex1, hex0}, {4'b0, eh});
  endtask

  // Drive one op away from the edge, sample the read before the edge, return just after it.
  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [9:0] s, input logic [3:0] k, output logic [31:0] pre);
    @(negedge clk);
    wrMEM = w; addr = a; dataIn = d; switches = s; keys = k;
    #1 pre = dataOut;
    @(posedge clk);
    #1;
  endtask

  localparam logic [27:0] HEX_ZERO = {4{7'b1000000}};
  localparam logic [27:0] HEX_BAD  = {7'b1000000, 7'b0000011, 7'b0001000, 7'b0100001};
  localparam logic [27:0] HEX_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

  initial begin
    logic [31:0] pre;
    logic [31:0] a, d, exp_d;
    logic [9:0]  s;
    logic [3:0]  k;
    logic        w;
    logic [10:0] wi;
    bit          cd;

    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // wr, addr, din, sw, keys, check-dout, dout(before edge), ledr, ledg, hex (after edge)
    tv.push_back(mkv(0, 32'h0,        32'h0,        10'h0,   4'h0, 0, 32'h0,        10'h0,   8'h0,  HEX_ZERO));
    tv.push_back(mkv(1, 32'hF0000000, 32'h00000BAD, 10'h0,   4'h0, 1, 32'h0,        10'h0,   8'h0,  HEX_BAD));
    tv.push_back(mkv(0, 32'hF0000014, 32'hF8F8F8F8, 10'h2AA, 4'h0, 1, 32'h000002AA, 10'h0,   8'h0,  HEX_BAD));
    tv.push_back(mkv(0, 32'hF0000010, 32'hF8F8F8F8, 10'h2AA, 4'h5, 1, 32'h00000005, 10'h0,   8'h0,  HEX_BAD));
    tv.push_back(mkv(1, 32'hF0000004, 32'hFF77FF77, 10'h0,   4'h0, 1, 32'h0,        10'h377, 8'h0,  HEX_BAD));
    tv.push_back(mkv(1, 32'hF0000008, 32'hFF0FFF0F, 10'h0,   4'h0, 1, 32'h0,        10'h377, 8'h0F, HEX_BAD));
    tv.push_back(mkv(1, 32'hF0000000, 32'h00001234, 10'h0,   4'h0, 1, 32'h00000BAD, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'hF0000000, 32'h0,        10'h0,   4'h0, 1, 32'h00001234, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'hF0000004, 32'h0,        10'h0,   4'h0, 1, 32'h00000377, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'hF0000008, 32'h0,        10'h0,   4'h0, 1, 32'h0000000F, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(1, 32'h00000100, 32'hDEADBEEF, 10'h0,   4'h0, 0, 32'h0,        10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(1, 32'h00000104, 32'h12345678, 10'h0,   4'h0, 0, 32'h0,        10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'h00000100, 32'h0,        10'h0,   4'h0, 1, 32'hDEADBEEF, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'h00000103, 32'h0,        10'h0,   4'h0, 1, 32'hDEADBEEF, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'h00000104, 32'h0,        10'h0,   4'h0, 1, 32'h12345678, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'h80002100, 32'h0,        10'h0,   4'h0, 1, 32'hDEADBEEF, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(1, 32'hF000000C, 32'hFFFFFFFF, 10'h0,   4'h0, 1, 32'h0,        10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'hF000000C, 32'h0,        10'h0,   4'h0, 1, 32'h0,        10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'h00000100, 32'h0,        10'h0,   4'h0, 1, 32'hDEADBEEF, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(1, 32'hF0000010, 32'hFFFFFFFF, 10'h0,   4'h5, 1, 32'h00000005, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'hF0000010, 32'h0,        10'h0,   4'h5, 1, 32'h00000005, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(1, 32'h00000100, 32'hCAFEF00D, 10'h0,   4'h0, 1, 32'hDEADBEEF, 10'h377, 8'h0F, HEX_1234));
    tv.push_back(mkv(0, 32'h00000100, 32'h0,        10'h0,   4'h0, 1, 32'hCAFEF00D, 10'h377, 8'h0F, HEX_1234));

    reset_n = 1'b0; wrMEM = 1'b0; addr = '0; dataIn = '0; switches = '0; keys = '0;
    #22 reset_n = 1'b1;

    chk("reset no-X", {31'b0, $isunknown({ledr, ledg, hex3, hex2, hex1, hex0})}, 32'h0);
    chk_io("reset", 10'h0, 8'h0, HEX_ZERO);

    foreach (tv[i]) begin
      drive(tv[i].wr, tv[i].a, tv[i].d, tv[i].sw, tv[i].k, pre);
      if (tv[i].cd) chk($sformatf("vec%0d dout", i), pre, tv[i].edout);
      chk_io($sformatf("vec%0d", i), tv[i].eledr, tv[i].eledg, tv[i].ehex);
    end

    // Asynchronous reset between edges: registers clear at once, RAM is untouched.
    drive(0, 32'h00000100, 32'h0, 10'h0, 4'h0, pre);
    #2 reset_n = 1'b0;
    #1 chk_io("async reset", 10'h0, 8'h0, HEX_ZERO);
    chk("ram kept during reset", dataOut, 32'hCAFEF00D);
    @(negedge clk);
    #2 reset_n = 1'b1;
    drive(0, 32'h00000104, 32'h0, 10'h0, 4'h0, pre);
    chk("ram kept after reset", pre, 32'h12345678);
    chk_io("post reset", 10'h0, 8'h0, HEX_ZERO);

    hexm = '0; ledrm = '0; ledgm = '0;
    foreach (mvalid[i]) mvalid[i] = 0;

    for (int n = 0; n < 600; n++) begin
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 10'($urandom);
      k = 4'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        a = $urandom;
        if (a[31:28] == 4'hF) a[31:28] = 4'h3;
        a[12:2] = 11'($urandom_range(0, 31));
      end else begin
        case ($urandom_range(0, 6))
          0: a = 32'hF0000000;
          1: a = 32'hF0000004;
          2: a = 32'hF0000008;
          3: a = 32'hF0000010;
          4: a = 32'hF0000014;
          5: a = 32'hF000000C;
          default: a = 32'hF0000000 | ($urandom & 32'h0FFFFFFC);
        endcase
      end

      // expected read value from the model, before this op's write lands
      cd = 1; wi = a[12:2]; exp_d = 32'h0;
      if (a[31:28] != 4'hF) begin
        cd = mvalid[wi];
        exp_d = mref[wi];
      end else if (a == 32'hF0000000) exp_d = 32'(hexm);
      else if (a == 32'hF0000004) exp_d = 32'(ledrm);
      else if (a == 32'hF0000008) exp_d = 32'(ledgm);
      else if (a == 32'hF0000010) exp_d = 32'(k);
      else if (a == 32'hF0000014) exp_d = 32'(s);

      drive(w, a, d, s, k, pre);
      if (cd) chk($sformatf("rnd%0d dout @%h", n, a), pre, exp_d);

      if (w) begin
        if (a[31:28] != 4'hF) begin
          mref[wi] = d; mvalid[wi] = 1;
        end else if (a == 32'hF0000000) hexm = d[15:0];
        else if (a == 32'hF0000004) ledrm = d[9:0];
        else if (a == 32'hF0000008) ledgm = d[7:0];
      end
      chk_io($sformatf("rnd%0d", n), ledrm, ledgm, hex_of(hexm));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
